instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch front end between the program counter and the instruction decoder. Reads the current PC value, issues one read per instruction to instruction memory over a req/ack handshake, and drives the program counter's increment enable once each fetch completes. Buffers fetched words with their addresses in a small FIFO and presents them to the decoder over a valid/ready handshake. A flush discards buffered and in-flight fetches on a branch or jump redirect.

## Interface
- WIDTH, 16, data and address width
- DEPTH, 4, FIFO entries; power of two, at least 2

- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-low
- pc_value  in  WIDTH  current program counter output
- pc_inc  out  1  increment pulse to the program counter's pc_enable, with select=0
- mem_req  out  1  read request to instruction memory
- mem_addr  out  WIDTH  read address; registered
- mem_ack  in  1  read complete; mem_rdata is valid this cycle
- mem_rdata  in  WIDTH  read data
- flush  in  1  redirect pulse; the PC is loaded externally in the same cycle
- halt  in  1  level; blocks new requests
- instr_valid  out  1  instr_data and instr_pc are valid
- instr_ready  in  1  decoder accepts the head entry
- instr_data  out  WIDTH  head instruction word
- instr_pc  out  WIDTH  address of the head instruction
- fetch_count  out  WIDTH  present only with IFETCH_STATS_EN

## Operation
- FSM states: IDLE, REQ, WAIT, DROP.
- Reset (rst low, asynchronous): state IDLE; FIFO empty; outputs pc_inc, mem_req, mem_addr, instr_valid, instr_data, instr_pc and fetch_count are all 0.
- IDLE → REQ when halt=0, flush=0 and count<DEPTH. On this edge, mem_addr is loaded with pc_value.
- REQ:
  - mem_req=1; mem_addr is held stable until ack.
  - On mem_ack: push {mem_addr, mem_rdata}, set pc_inc_q=1, go to WAIT.
- WAIT: pc_inc_q is high for exactly this one cycle; always → IDLE. This gives the PC one edge to update before the next address is latched.
- pc_inc = pc_inc_q & ~flush. A redirect load always beats an increment.
- DROP: mem_req=1 and address held. On mem_ack the data is discarded, no pc_inc is generated, → IDLE.
- Flush handling by state:
  - IDLE: no REQ entry on that edge.
  - REQ without ack: → DROP.
  - REQ with ack on the same edge: data discarded, pc_inc_q stays 0, → IDLE.
  - WAIT: pc_inc suppressed, → IDLE.
  - DROP: stays DROP.
- Flush always empties the FIFO on that edge; a coincident pop is ignored.
- The request protocol is never aborted: once mem_req rises it stays high with a constant mem_addr until mem_ack.
- FIFO:
  - instr_valid = count≠0; the head entry is shown on instr_data/instr_pc.
  - Pop on instr_valid & instr_ready.
  - Push and pop on the same edge leave count unchanged.
  - The FIFO is never full at a push, because REQ is entered only with count<DEPTH and there is at most one request outstanding.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- halt does not affect REQ, WAIT or DROP, and does not block pops.

## Timing
- Fetch cost: 1 cycle (IDLE) + L cycles (REQ, where mem_ack arrives L≥1 cycles after mem_req rises) + 1 cycle (WAIT) per instruction. With L=1, steady-state throughput is 1 instruction per 3 cycles.
- Push to instr_valid: 1 cycle. The entry becomes visible the cycle after the ack edge.
- mem_ack is sampled only in REQ and DROP; it is ignored in IDLE and WAIT.
- Flush to first new request: the next IDLE→REQ edge latches the redirected pc_value. In the minimum case that is 1 cycle after flush from IDLE/WAIT, or after the outstanding ack from REQ/DROP.

## Configuration
- IFETCH_STATS_EN defined:
  - Adds the fetch_count output, reset to 0.
  - Increments on every push, i.e. accepted fetch, wrapping at 2^WIDTH.
  - Dropped fetches are not counted; flush does not clear it.
- IFETCH_STATS_EN undefined: no fetch_count port and no counter logic. All other behaviour is identical.

## Test plan
- Reset then straight-line fetch: hold pc_value at 0x0000, with a model PC incrementing on pc_inc. Memory returns 0x1000+addr with L=1; instr_ready=1. Required: decoder receives (pc 0x0000, data 0x1000), (0x0001, 0x1001), (0x0002, 0x1002), spaced 3 cycles apart, with pc_inc pulsed once per fetch.
- Backpressure: instr_ready=0 for 20 cycles. Required: exactly DEPTH=4 entries (pc 0–3) are buffered, mem_req stays low after the 4th ack, and the PC stops at 4. Then raise instr_ready: entries drain in order 0–3 and fetching resumes at pc 4.
- Flush during REQ with L=3: assert flush on the cycle after mem_req rises, and load the model PC with 0x0040. Required: the pending ack is discarded with no pc_inc, the FIFO is empty, and the next mem_addr is 0x0040.
- Flush coincident with ack, and separately with the WAIT cycle. Required: pc_inc stays 0, no entry is pushed, and the next fetch address is the redirected value.
- Simultaneous push and pop at count=1, plus halt: count stays 1 with order preserved. With halt=1 raised while in REQ, that fetch completes, then mem_req stays 0 until halt drops.
- IFETCH_STATS_EN: 10 fetches plus 2 dropped fetches. Required: fetch_count=10. Asserting rst low mid-REQ forces fetch_count=0, mem_req=0 and instr_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch front end between the program counter and the decoder.
// Issues one instruction-memory read per instruction, pulses pc_inc once per
// accepted fetch, buffers {address, word} pairs in a DEPTH-entry FIFO and
// presents the head entry to the decoder. flush discards buffered and
// in-flight fetches.
// Optional feature: define IFETCH_STATS_EN to add the fetch_count output.
//
// Handshakes:
//   memory  : mem_req rises with mem_addr and both stay constant until the
//             cycle where mem_ack is high; the ack edge completes the read.
//   decoder : an entry transfers on every rising edge where instr_valid and
//             instr_ready are both high (and flush is low).
module instruction_fetch #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_value,
  output logic             pc_inc,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             flush,
  input  logic             halt,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] instr_data,
  output logic [WIDTH-1:0] instr_pc,
  output logic [1:0]       fsm_state
`ifdef IFETCH_STATS_EN
  ,
  output logic [WIDTH-1:0] fetch_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t state, next_state;
  logic   pc_inc_q;
  logic   load_addr;
  logic   push;
  logic   set_inc;
  logic   pop;

  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW:0]      count;
  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [WIDTH-1:0] pc_mem   [DEPTH];

  // Next-state and per-edge actions; flush wins over every transition.
  always_comb begin
    next_state = state;
    load_addr  = 1'b0;
    push       = 1'b0;
    set_inc    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!halt && !flush && (count < CNT_FULL)) begin
          next_state = REQ;
          load_addr  = 1'b1;
        end
      end
      REQ: begin
        if (mem_ack) begin
          if (flush) begin
            next_state = IDLE;
          end else begin
            push       = 1'b1;
            set_inc    = 1'b1;
            next_state = WAIT;
          end
        end else if (flush) begin
          next_state = DROP;
        end
      end
      WAIT: next_state = IDLE;
      DROP: begin
        if (mem_ack) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register, increment pulse and the registered read address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pc_inc_q <= 1'b0;
      mem_addr <= '0;
    end else begin
      state    <= next_state;
      pc_inc_q <= set_inc;
      if (load_addr) mem_addr <= pc_value;
    end
  end

  // A redirect load in the same cycle always beats the increment.
  assign pc_inc      = pc_inc_q & ~flush;
  assign mem_req     = (state == REQ) || (state == DROP);
  assign instr_valid = (count != '0);
  assign pop         = instr_valid & instr_ready & ~flush;
  assign fsm_state   = state;

  // FIFO pointers and occupancy; flush empties the buffer on its edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + (PW+1)'(1);
      else if (pop && !push) count <= count - (PW+1)'(1);
    end
  end

  // FIFO storage; contents are only observable while counted as valid.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= mem_rdata;
      pc_mem[wr_ptr]   <= mem_addr;
    end
  end

  // Head entry is forced to zero when the FIFO is empty so reset shows zeros.
  assign instr_data = instr_valid ? data_mem[rd_ptr] : '0;
  assign instr_pc   = instr_valid ? pc_mem[rd_ptr]   : '0;

`ifdef IFETCH_STATS_EN
  // Accepted-fetch counter; dropped fetches and flushes leave it untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fetch_count <= '0;
    else if (push) fetch_count <= fetch_count + WIDTH'(1);
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios followed by a randomized
// phase, all checked against a transaction-level model of the fetch stream.
module tb_instruction_fetch;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] pc_value;
  logic             pc_inc;
  logic             mem_req;
  logic [WIDTH-1:0] mem_addr;
  logic             mem_ack;
  logic [WIDTH-1:0] mem_rdata;
  logic             flush;
  logic             halt;
  logic             instr_valid;
  logic             instr_ready;
  logic [WIDTH-1:0] instr_data;
  logic [WIDTH-1:0] instr_pc;
  logic [1:0]       fsm_state;
`ifdef IFETCH_STATS_EN
  logic [WIDTH-1:0] fetch_count;
`endif

  instruction_fetch #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_value    (pc_value),
    .pc_inc      (pc_inc),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .flush       (flush),
    .halt        (halt),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_data  (instr_data),
    .instr_pc    (instr_pc),
    .fsm_state   (fsm_state)
`ifdef IFETCH_STATS_EN
    ,
    .fetch_count (fetch_count)
`endif
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // scoreboard: expected FIFO contents, each entry {pc, word}
  logic [31:0] exp_q[$];

  // transaction model
  bit               m_req;      // a read is outstanding on the bus
  bit               m_cool;     // cycle right after an accepted fetch
  bit               m_killed;   // outstanding read was hit by a flush
  logic [WIDTH-1:0] m_addr;
  logic [WIDTH-1:0] m_pc;
  int               m_fetches;

  // memory responder and stimulus controls
  int               fixed_lat;
  int               req_cyc;
  int               cur_lat;
  bit               ack_noise;
  logic [WIDTH-1:0] flush_target;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] mem_word(input logic [WIDTH-1:0] a);
    return a + 16'h1000;
  endfunction

  task automatic reset_model();
    exp_q.delete();
    m_req     = 1'b0;
    m_cool    = 1'b0;
    m_killed  = 1'b0;
    m_addr    = '0;
    m_pc      = '0;
    m_fetches = 0;
    req_cyc   = 0;
    mem_ack   = 1'b0;
    pc_value  = '0;
  endtask

  task automatic reset_checks();
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_pc_inc", pc_inc, 0);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_instr_data", instr_data, 0);
    check("rst_instr_pc", instr_pc, 0);
`ifdef IFETCH_STATS_EN
    check("rst_fetch_count", fetch_count, 0);
`endif
  endtask

  // memory answers the L-th cycle of a request; optional spurious acks when idle
  task automatic drive_mem();
    if (mem_req) begin
      req_cyc++;
      mem_ack   = (req_cyc == cur_lat);
      mem_rdata = mem_word(mem_addr);
    end else begin
      req_cyc   = 0;
      cur_lat   = (fixed_lat != 0) ? fixed_lat : $urandom_range(1, 3);
      mem_ack   = ack_noise && ($urandom_range(0, 3) == 0);
      mem_rdata = 16'($urandom);
    end
  endtask

  // one clock cycle: drive memory, check outputs, advance the model, clock
  task automatic tick();
    logic [31:0] front;
    int          size_b;
    bit          exp_inc;
    bit          accepted;
    drive_mem();
    #1;
    exp_inc = m_cool && !flush;
    check("mem_req", mem_req, m_req);
    if (m_req) check("mem_addr", mem_addr, m_addr);
    check("pc_inc", pc_inc, exp_inc);
    check("instr_valid", instr_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      front = exp_q[0];
      check("instr_pc", instr_pc, front[31:16]);
      check("instr_data", instr_data, front[15:0]);
    end
`ifdef IFETCH_STATS_EN
    check("fetch_count", fetch_count, 16'(m_fetches));
`endif
    size_b = exp_q.size();
    if (size_b != 0 && instr_ready && !flush) void'(exp_q.pop_front());
    if (m_req) begin
      if (mem_ack) begin
        accepted = !m_killed && !flush;
        if (accepted) begin
          exp_q.push_back({m_addr, mem_word(m_addr)});
          m_fetches++;
        end
        m_req  = 1'b0;
        m_cool = accepted;
      end else begin
        m_killed = m_killed | flush;
      end
    end else if (m_cool) begin
      m_cool = 1'b0;
    end else if (!halt && !flush && size_b < DEPTH) begin
      m_req    = 1'b1;
      m_addr   = m_pc;
      m_killed = 1'b0;
    end
    if (flush) exp_q.delete();
    if (flush) m_pc = flush_target;
    else if (exp_inc) m_pc = m_pc + 16'd1;
    @(posedge clk);
    @(negedge clk);
    pc_value = m_pc;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20 && !mem_req; i++) tick();
    check("wait_mem_req", mem_req, 1);
  endtask

  initial begin
    rst          = 1'b0;
    flush        = 1'b0;
    halt         = 1'b0;
    instr_ready  = 1'b1;
    mem_rdata    = '0;
    fixed_lat    = 1;
    ack_noise    = 1'b0;
    flush_target = '0;
    cur_lat      = 1;
    reset_model();
    #2;
    reset_checks();
    @(negedge clk);
    rst = 1'b1;

    // straight-line fetch, L=1, decoder always ready
    run(12);

    // backpressure: FIFO fills to DEPTH and requests stop
    instr_ready = 1'b0;
    run(20);
    check("bp_mem_req_low", mem_req, 0);
    check("bp_valid", instr_valid, 1);
    instr_ready = 1'b1;
    run(20);

    // flush in the second cycle of a 3-cycle request
    fixed_lat = 3;
    wait_req();
    tick();
    flush = 1'b1; flush_target = 16'h0040;
    tick();
    flush = 1'b0;
    run(12);

    // flush coincident with the ack
    fixed_lat = 1;
    wait_req();
    flush = 1'b1; flush_target = 16'h0100;
    tick();
    flush = 1'b0;
    run(6);

    // flush during the increment cycle
    for (int i = 0; i < 20 && pc_inc !== 1'b1; i++) tick();
    check("wait_pc_inc", pc_inc, 1);
    flush = 1'b1; flush_target = 16'h0200;
    tick();
    flush = 1'b0;
    run(6);

    // halt raised mid-request: that fetch completes, then no new requests
    fixed_lat = 3;
    wait_req();
    halt = 1'b1;
    run(12);
    check("halt_mem_req_low", mem_req, 0);
    halt = 1'b0;
    run(10);

    // asynchronous reset in the middle of a request
    wait_req();
    #2;
    rst = 1'b0;
    #1;
    reset_checks();
    reset_model();
    @(negedge clk);
    rst = 1'b1;
    run(4);

    // randomized traffic
    fixed_lat = 0;
    ack_noise = 1'b1;
    for (int i = 0; i < 900; i++) begin
      instr_ready  = ($urandom_range(0, 3) != 0);
      flush        = ($urandom_range(0, 14) == 0);
      flush_target = 16'($urandom);
      if ($urandom_range(0, 9) == 0) halt = ~halt;
      tick();
    end
    flush       = 1'b0;
    halt        = 1'b0;
    instr_ready = 1'b1;
    run(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
